// File: rtl/pico_pkg.sv
// Shared definitions for the pico core sequencing logic.
// Holds the sequencer state encoding and the default pc / branch-offset widths.
// Optional macro PC_SEQUENCER_HALT_LOOP_EN adds the HALT state to the encoding.
package pico_pkg;

  localparam int unsigned PICO_PC_W  = 8;
  localparam int unsigned PICO_OFF_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_WAIT_OUT = 2'd2
`ifdef PC_SEQUENCER_HALT_LOOP_EN
    , ST_HALT   = 2'd3
`endif
  } seq_state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-pc generator: pc+1, or pc plus a sign-extended relative
// offset, wrapping modulo 2^PC_W.
// Ports:
//   pc            current instruction address
//   branch        1 = relative branch, 0 = sequential increment
//   branch_offset two's-complement branch displacement
//   next_pc       candidate address for the next instruction
module pc_next
  import pico_pkg::*;
#(
  parameter int unsigned PC_W  = PICO_PC_W,
  parameter int unsigned OFF_W = PICO_OFF_W
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             branch,
  input  logic [OFF_W-1:0] branch_offset,
  output logic [PC_W-1:0]  next_pc
);

  // Work at the wider of the two widths; truncation to PC_W gives the wrap.
  localparam int unsigned SUM_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  logic [SUM_W-1:0] off_ext;
  logic [SUM_W-1:0] pc_ext;
  logic [SUM_W-1:0] addend;
  logic [SUM_W-1:0] sum;

  assign off_ext = SUM_W'($signed(branch_offset));
  assign pc_ext  = SUM_W'(pc);
  assign addend  = branch ? off_ext : SUM_W'(1);
  assign sum     = pc_ext + addend;
  assign next_pc = PC_W'(sum);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with STIN/LOUT handshake stalls.
// Advances pc by one or by a relative branch, and holds the current
// instruction while an input read or output write waits for its partner.
// Optional macro PC_SEQUENCER_HALT_LOOP_EN: a jump-to-self branch parks the
// sequencer in HALT until reset.
// Ports:
//   clk, n_reset      clock, asynchronous active-low reset
//   pc_rel_branch     decoder: relative branch taken
//   branch_offset     decoder: signed branch displacement
//   reg_write         decoder: register-file write
//   read_in           decoder: STIN (consume input word)
//   write_out         decoder: LOUT (produce output word)
//   in_valid/in_ready input handshake
//   out_valid/out_ready output handshake
//   pc                current instruction address (registered)
//   reg_we            register write enable, gated by instruction completion
//   stall             current instruction is held this cycle
// in_ready, out_valid, reg_we and stall are combinational handshake outputs.
module pc_sequencer
  import pico_pkg::*;
#(
  parameter int unsigned PC_W  = PICO_PC_W,
  parameter int unsigned OFF_W = PICO_OFF_W
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             pc_rel_branch,
  input  logic [OFF_W-1:0] branch_offset,
  input  logic             reg_write,
  input  logic             read_in,
  input  logic             write_out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  pc,
  output logic             reg_we,
  output logic             stall
);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_calc;
  logic            take_branch;
  logic            done;

  // I/O has priority over a branch; a branch only counts in RUN.
  assign take_branch = (state_q == ST_RUN) && pc_rel_branch && !read_in && !write_out;

  pc_next #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next (
    .pc            (pc_q),
    .branch        (take_branch),
    .branch_offset (branch_offset),
    .next_pc       (pc_calc)
  );

  // Next-state, handshake and completion decode.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (read_in) begin
          in_ready = 1'b1;
          if (in_valid) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT_IN;
          end
        end else if (write_out) begin
          out_valid = 1'b1;
          if (out_ready) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT_OUT;
          end
        end else begin
          done = 1'b1;
`ifdef PC_SEQUENCER_HALT_LOOP_EN
          if (pc_rel_branch && (branch_offset == '0)) begin
            state_d = ST_HALT;
          end
`endif
        end
      end
      ST_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          done    = 1'b1;
          state_d = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      ST_WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done    = 1'b1;
          state_d = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end
`ifdef PC_SEQUENCER_HALT_LOOP_EN
      ST_HALT: begin
        stall = 1'b1;
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase

    reg_we = reg_write && done;
    pc_d   = done ? pc_calc : pc_q;

    // Reset silences every handshake output immediately, independent of clk.
    if (!n_reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      stall     = 1'b0;
      reg_we    = 1'b0;
    end
  end

  // State and pc registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer.
// A driver applies one instruction-cycle vector per clock, runs a behavioural
// model of the sequencer and queues the expected outputs; a monitor pops one
// expectation per cycle on the falling edge and compares.
module tb_pc_sequencer;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned OFF_W   = 8;
  localparam int          PC_MASK = (1 << PC_W) - 1;

  // Model modes: 0 running, 1 waiting for input, 2 waiting for sink, 3 halted.
  localparam int MODE_RUN  = 0;
  localparam int MODE_HALT = 3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            stall;
    logic            in_ready;
    logic            out_valid;
    logic            reg_we;
  } exp_t;

  logic             clk = 1'b0;
  logic             n_reset;
  logic             pc_rel_branch;
  logic [OFF_W-1:0] branch_offset;
  logic             reg_write;
  logic             read_in;
  logic             write_out;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  pc;
  logic             reg_we;
  logic             stall;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_pc     = 0;
  int   m_mode   = MODE_RUN;
  exp_t sb_q[$];

  pc_sequencer #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .pc_rel_branch (pc_rel_branch),
    .branch_offset (branch_offset),
    .reg_write     (reg_write),
    .read_in       (read_in),
    .write_out     (write_out),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pc            (pc),
    .reg_we        (reg_we),
    .stall         (stall)
  );

  always #5 clk = ~clk;

  // Directed immediate check.
  task automatic check_now(input bit cond, input string name);
    checks++;
    if (!cond) begin
      failures++;
      $display("FAIL %s t=%0t pc=%0d stall=%b in_ready=%b out_valid=%b reg_we=%b",
               name, $time, pc, stall, in_ready, out_valid, reg_we);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge and queue the
  // expected outputs for that cycle from the behavioural model.
  task automatic step(input logic rst, input logic br, input logic [OFF_W-1:0] off,
                      input logic rw, input logic rd, input logic wr,
                      input logic iv, input logic ordy);
    exp_t e;
    int   kind;
    bit   ok;
    @(posedge clk);
    #1;
    n_reset       = rst;
    pc_rel_branch = br;
    branch_offset = off;
    reg_write     = rw;
    read_in       = rd;
    write_out     = wr;
    in_valid      = iv;
    out_ready     = ordy;

    e = '0;
    if (!rst) begin
      m_pc   = 0;
      m_mode = MODE_RUN;
    end else begin
      e.pc = PC_W'(m_pc);
      if (m_mode == MODE_HALT) begin
        e.stall = 1'b1;
      end else begin
        // kind: 0 plain instruction, 1 input read, 2 output write
        if (m_mode == MODE_RUN) kind = rd ? 1 : (wr ? 2 : 0);
        else                    kind = m_mode;
        e.in_ready  = (kind == 1);
        e.out_valid = (kind == 2);
        ok = (kind == 0) || (kind == 1 && iv) || (kind == 2 && ordy);
        e.stall  = !ok;
        e.reg_we = rw && ok;
        if (!ok) begin
          m_mode = kind;
        end else begin
          m_mode = MODE_RUN;
          if (kind == 0 && br) begin
            m_pc = (m_pc + int'($signed(off))) & PC_MASK;
`ifdef PC_SEQUENCER_HALT_LOOP_EN
            if (off == '0) m_mode = MODE_HALT;
`endif
          end else begin
            m_pc = (m_pc + 1) & PC_MASK;
          end
        end
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t w;
    exp_t g;
    if (sb_q.size() > 0) begin
      w = sb_q.pop_front();
      g = '{pc: pc, stall: stall, in_ready: in_ready, out_valid: out_valid, reg_we: reg_we};
      checks++;
      if (g !== w) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d got pc=%0d stall=%b in_ready=%b out_valid=%b reg_we=%b want pc=%0d stall=%b in_ready=%b out_valid=%b reg_we=%b",
                 cyc, g.pc, g.stall, g.in_ready, g.out_valid, g.reg_we,
                 w.pc, w.stall, w.in_ready, w.out_valid, w.reg_we);
      end
      cyc++;
    end
  end

  initial begin
    n_reset       = 1'b0;
    pc_rel_branch = 1'b0;
    branch_offset = '0;
    reg_write     = 1'b0;
    read_in       = 1'b0;
    write_out     = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;

    // reset, then free-running increments 0..5
    step(0, 0, 8'h00, 0, 0, 0, 0, 0);
    #1;
    check_now((pc === 8'd0) && (stall === 1'b0) && (in_ready === 1'b0) &&
              (out_valid === 1'b0) && (reg_we === 1'b0), "reset_state");
    step(0, 0, 8'h00, 1, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 0, 0, 0, 0, 0);
    // 6 -> 133 -> 250 via branches
    step(1, 1, 8'd127, 0, 0, 0, 0, 0);   // 6 -> 133
    step(1, 1, 8'd117, 0, 0, 0, 0, 0);   // 133 -> 250
    step(1, 1, 8'd10,  1, 0, 0, 0, 0);   // 250 -> 4 (wrap)
    step(1, 1, 8'hFF,  0, 0, 0, 0, 0);   // 4 -> 3
    step(1, 1, 8'hFB,  0, 0, 0, 0, 0);   // 3 -> 254 (negative wrap)
    // STIN with input late by three cycles
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 1, 0, 0, 0);
    #1;
    check_now((stall === 1'b1) && (in_ready === 1'b1) && (pc === 8'd254) &&
              (reg_we === 1'b0), "wait_in_pending");
    step(1, 0, 8'h00, 1, 1, 0, 1, 0);    // accept at 254 -> 255
    // LOUT accepted immediately, branch ignored
    step(1, 1, 8'h40, 0, 0, 1, 0, 1);    // 255 -> 0
    // LOUT with sink stalled for two cycles
    step(1, 0, 8'h00, 1, 0, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 1, 0, 1);    // 0 -> 1
    // STIN with branch: I/O wins, zero-stall read
    step(1, 1, 8'h20, 1, 1, 0, 1, 0);    // 1 -> 2
    // reset dropped in the middle of WAIT_IN
    step(1, 0, 8'h00, 1, 1, 0, 0, 0);
    step(1, 0, 8'h00, 1, 1, 0, 0, 0);
    step(0, 0, 8'h00, 1, 1, 0, 0, 0);
    #1;
    check_now((pc === 8'd0) && (in_ready === 1'b0) && (reg_we === 1'b0) &&
              (stall === 1'b0), "async_reset_mid_wait");
    step(0, 0, 8'h00, 1, 1, 0, 1, 0);
    // first cycle after reset runs pc 0; branch to 7 then jump-to-self
    step(1, 1, 8'd7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 8'h00, 1, 0, 0, 0, 0);
    // I/O requests while parked at the self-loop
    step(1, 0, 8'h00, 1, 1, 0, 1, 0);
    step(1, 0, 8'h00, 1, 0, 1, 0, 1);
    step(0, 0, 8'h00, 0, 0, 0, 0, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) == 0),
           OFF_W'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program counter width in bits.
REQ-002 Parameter OFF_W, default 8: branch offset width in bits (two's complement).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 n_reset  input  1  reset, asynchronous and active-low.
REQ-005 pc_rel_branch  input  1  decoder branch-taken control.
REQ-006 branch_offset  input  OFF_W  signed relative offset from the instruction immediate.
REQ-007 reg_write  input  1  decoder register-write control.
REQ-008 read_in  input  1  decoder STIN control.
REQ-009 write_out  input  1  decoder LOUT control.
REQ-010 in_valid  input  1  external input data valid.
REQ-011 in_ready  output  1  sequencer accepts input data this cycle.
REQ-012 out_valid  output  1  sequencer presents output data this cycle.
REQ-013 out_ready  input  1  external sink accepts output data.
REQ-014 pc  output  PC_W  current instruction address.
REQ-015 reg_we  output  1  gated register-file write enable.
REQ-016 stall  output  1  the current instruction is held (pc does not advance).

Function
REQ-017 States: RUN, WAIT_IN, WAIT_OUT (plus HALT when enabled, see Configuration).
REQ-018 In RUN with no I/O pending, pc SHALL become pc+1 next cycle, or pc+sext(branch_offset) when pc_rel_branch=1.
REQ-019 All pc arithmetic SHALL be modulo 2^PC_W (wrap from max to 0, negative offsets wrap downward).
REQ-020 read_in=1 in RUN SHALL assert in_ready combinationally; if in_valid=1 in the same cycle, the instruction completes with zero stall cycles.
REQ-021 read_in=1 and in_valid=0 in RUN SHALL move to WAIT_IN, hold pc and assert stall.
REQ-022 In WAIT_IN, in_ready=1 and stall=1; on in_valid=1, return to RUN and advance pc by one.
REQ-023 write_out=1 in RUN SHALL assert out_valid combinationally; out_ready=1 in the same cycle completes the transfer with zero stall cycles.
REQ-024 write_out=1 and out_ready=0 SHALL move to WAIT_OUT, where out_valid and stall stay 1 and pc holds until out_ready=1, then return to RUN and advance pc by one.
REQ-025 reg_we = reg_write AND the instruction completing this cycle, so a STIN writes exactly once, in its accepting cycle.
REQ-026 pc_rel_branch together with read_in or write_out (illegal decoder output) SHALL be resolved by letting I/O take priority, ignoring the branch.
REQ-027 in_ready and out_valid SHALL never be asserted in the same cycle.

Reset
REQ-028 While n_reset=0: pc=0, state=RUN, stall=0, in_ready=0, out_valid=0, reg_we=0, regardless of clk.
REQ-029 Reset asserted during WAIT_IN or WAIT_OUT SHALL abandon the handshake, with no completion and no reg_we.
REQ-030 After n_reset deasserts, the first posedge SHALL evaluate the instruction at pc=0.

Configuration
REQ-031 Macro PC_SEQUENCER_HALT_LOOP_EN:
- Defined: pc_rel_branch=1 with branch_offset=0 (jump-to-self) SHALL enter HALT. In HALT, pc holds, stall=1, reg_we=0 and I/O is idle. Only reset exits HALT.
- Undefined: no HALT state exists, and jump-to-self loops normally with stall=0.

Structure
REQ-032 Shared package pico_pkg SHALL hold the seq_state_t enum and the PC_W/OFF_W default constants.
REQ-033 The next-pc computation (increment, sign-extend, add, wrap) SHALL be a combinational sub-module pc_next; the FSM and handshake logic stay in pc_sequencer.

Verification
REQ-034 Reset, then 5 cycles with no controls -> pc goes 0,1,2,3,4,5; stall=0.
REQ-035 pc=250 (PC_W=8), branch with offset=+10 -> pc=4 next cycle; pc=3, offset=-5 (0xFB) -> pc=254.
REQ-036 read_in=1, reg_write=1, in_valid low 3 cycles then high -> stall=1 for 3 cycles, pc held, reg_we=1 for exactly one cycle, then pc+1.
REQ-037 write_out=1, out_ready=1 in the same cycle -> out_valid pulses one cycle, no stall, pc+1; with out_ready=0 for 2 cycles -> WAIT_OUT for 2 cycles, out_valid stable.
REQ-038 n_reset pulled low mid-WAIT_IN -> pc=0, in_ready=0 immediately (asynchronous), no reg_we.
REQ-039 With PC_SEQUENCER_HALT_LOOP_EN, branch offset=0 at pc=7 -> pc stays 7, stall=1 indefinitely until reset; without the macro -> pc stays 7 and stall=0.
